// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants and counter widths shared by the Pong core
// and its output sync stage.
package vga_timing_pkg;

   localparam int unsigned H_TOTAL       = 800;
   localparam int unsigned V_TOTAL       = 525;
   localparam int unsigned H_ACTIVE      = 640;
   localparam int unsigned V_ACTIVE      = 480;
   localparam int unsigned H_FRONT_PORCH = 18;
   localparam int unsigned H_BACK_PORCH  = 50;
   localparam int unsigned V_FRONT_PORCH = 10;
   localparam int unsigned V_BACK_PORCH  = 33;

   localparam int unsigned COL_CNT_W = $clog2(H_TOTAL);
   localparam int unsigned ROW_CNT_W = $clog2(V_TOTAL);

endpackage

// File: rtl/sync_to_count_rst.sv
// Registers HSync/VSync and rebuilds column/row counts from them; a rising
// registered VSync marks frame start and zeroes both counts on that sample.
module sync_to_count_rst
   import vga_timing_pkg::*;
#(
   parameter int unsigned TOTAL_COLS = H_TOTAL,
   parameter int unsigned TOTAL_ROWS = V_TOTAL,
   parameter int unsigned COL_W      = $clog2(TOTAL_COLS),
   parameter int unsigned ROW_W      = $clog2(TOTAL_ROWS)
) (
   input  logic             i_Clk,
   input  logic             i_Rst_L,
   input  logic             i_HSync,
   input  logic             i_VSync,
   output logic             o_HSync,
   output logic             o_VSync,
   output logic [COL_W-1:0] o_Col_Count,
   output logic [ROW_W-1:0] o_Row_Count
);

   localparam logic [COL_W-1:0] ColLast = COL_W'(TOTAL_COLS - 1);
   localparam logic [ROW_W-1:0] RowLast = ROW_W'(TOTAL_ROWS - 1);

   logic             hsync_q, vsync_q;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;

   // vsync_q is the previous registered VSync, so this edge lands on the sample
   // being captured now and its counts become zero together with it.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (i_VSync && !vsync_q) begin
         col_d = '0;
         row_d = '0;
      end else if (col_q == ColLast) begin
         col_d = '0;
         row_d = (row_q == RowLast) ? '0 : row_q + ROW_W'(1);
      end else begin
         col_d = col_q + COL_W'(1);
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         hsync_q <= i_HSync;
         vsync_q <= i_VSync;
         col_q   <= col_d;
         row_q   <= row_d;
      end
   end

   assign o_HSync     = hsync_q;
   assign o_VSync     = vsync_q;
   assign o_Col_Count = col_q;
   assign o_Row_Count = row_q;

endmodule

// File: rtl/vga_sync_porch.sv
// Output stage for the VGA pins: porched active-low syncs and blanked video,
// two clocks behind the game's sync/video inputs.
module vga_sync_porch
   import vga_timing_pkg::*;
#(
   parameter int unsigned VIDEO_WIDTH   = 4,
   parameter int unsigned TOTAL_COLS    = H_TOTAL,
   parameter int unsigned TOTAL_ROWS    = V_TOTAL,
   parameter int unsigned ACTIVE_COLS   = H_ACTIVE,
   parameter int unsigned ACTIVE_ROWS   = V_ACTIVE,
   parameter int unsigned FRONT_PORCH_H = H_FRONT_PORCH,
   parameter int unsigned BACK_PORCH_H  = H_BACK_PORCH,
   parameter int unsigned FRONT_PORCH_V = V_FRONT_PORCH,
   parameter int unsigned BACK_PORCH_V  = V_BACK_PORCH
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_L,
   input  logic                   i_HSync,
   input  logic                   i_VSync,
   input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
   input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
   input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
   output logic                   o_HSync,
   output logic                   o_VSync,
   output logic [VIDEO_WIDTH-1:0] o_Red_Video,
   output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
   output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

   localparam int unsigned ColW = $clog2(TOTAL_COLS);
   localparam int unsigned RowW = $clog2(TOTAL_ROWS);

   // Sync pulse spans [Start, End] inclusive.
   localparam logic [ColW-1:0] HSyncStart = ColW'(ACTIVE_COLS + FRONT_PORCH_H);
   localparam logic [ColW-1:0] HSyncEnd   = ColW'(TOTAL_COLS - BACK_PORCH_H - 1);
   localparam logic [RowW-1:0] VSyncStart = RowW'(ACTIVE_ROWS + FRONT_PORCH_V);
   localparam logic [RowW-1:0] VSyncEnd   = RowW'(TOTAL_ROWS - BACK_PORCH_V - 1);

   logic                   s1_hsync, s1_vsync;
   logic [ColW-1:0]        s1_col;
   logic [RowW-1:0]        s1_row;
   logic [VIDEO_WIDTH-1:0] s1_red_q, s1_grn_q, s1_blu_q;

   logic                   hsync_q, hsync_d, vsync_q, vsync_d;
   logic [VIDEO_WIDTH-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;

   sync_to_count_rst #(
      .TOTAL_COLS (TOTAL_COLS),
      .TOTAL_ROWS (TOTAL_ROWS),
      .COL_W      (ColW),
      .ROW_W      (RowW)
   ) u_sync_to_count (
      .i_Clk       (i_Clk),
      .i_Rst_L     (i_Rst_L),
      .i_HSync     (i_HSync),
      .i_VSync     (i_VSync),
      .o_HSync     (s1_hsync),
      .o_VSync     (s1_vsync),
      .o_Col_Count (s1_col),
      .o_Row_Count (s1_row)
   );

   always_comb begin
      hsync_d = (s1_col < HSyncStart) || (s1_col > HSyncEnd);
      vsync_d = (s1_row < VSyncStart) || (s1_row > VSyncEnd);
      red_d   = '0;
      grn_d   = '0;
      blu_d   = '0;
      if (s1_hsync && s1_vsync) begin
         red_d = s1_red_q;
         grn_d = s1_grn_q;
         blu_d = s1_blu_q;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         s1_red_q <= '0;
         s1_grn_q <= '0;
         s1_blu_q <= '0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         red_q    <= '0;
         grn_q    <= '0;
         blu_q    <= '0;
      end else begin
         s1_red_q <= i_Red_Video;
         s1_grn_q <= i_Grn_Video;
         s1_blu_q <= i_Blu_Video;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         red_q    <= red_d;
         grn_q    <= grn_d;
         blu_q    <= blu_d;
      end
   end

   assign o_HSync     = hsync_q;
   assign o_VSync     = vsync_q;
   assign o_Red_Video = red_q;
   assign o_Grn_Video = grn_q;
   assign o_Blu_Video = blu_q;

endmodule

// File: tb/tb_vga_sync_porch.sv
// Drives a default-timing DUT and a shrunken-timing DUT with one shared stream and
// checks both against a sample-position reference model.
module tb_vga_sync_porch;

   // Shrunken timing: 40x20 total, 32x14 active, 800 clocks per frame.
   localparam int STC = 40, STR = 20, SAC = 32, SAR = 14;
   localparam int SFPH = 2, SBPH = 4, SFPV = 1, SBPV = 2;
   localparam int DTC = 800, DTR = 525, DAC = 640, DAR = 480;
   localparam int DFPH = 18, DBPH = 50, DFPV = 10, DBPV = 33;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_hs, in_vs;
   logic [3:0] in_r, in_g, in_b;
   logic       s_hs, s_vs, d_hs, d_vs;
   logic [3:0] s_r, s_g, s_b, d_r, d_g, d_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   vga_sync_porch #(
      .VIDEO_WIDTH   (4),
      .TOTAL_COLS    (STC),
      .TOTAL_ROWS    (STR),
      .ACTIVE_COLS   (SAC),
      .ACTIVE_ROWS   (SAR),
      .FRONT_PORCH_H (SFPH),
      .BACK_PORCH_H  (SBPH),
      .FRONT_PORCH_V (SFPV),
      .BACK_PORCH_V  (SBPV)
   ) u_dut_small (
      .i_Clk       (clk),
      .i_Rst_L     (rst_n),
      .i_HSync     (in_hs),
      .i_VSync     (in_vs),
      .i_Red_Video (in_r),
      .i_Grn_Video (in_g),
      .i_Blu_Video (in_b),
      .o_HSync     (s_hs),
      .o_VSync     (s_vs),
      .o_Red_Video (s_r),
      .o_Grn_Video (s_g),
      .o_Blu_Video (s_b)
   );

   vga_sync_porch u_dut_dflt (
      .i_Clk       (clk),
      .i_Rst_L     (rst_n),
      .i_HSync     (in_hs),
      .i_VSync     (in_vs),
      .i_Red_Video (in_r),
      .i_Grn_Video (in_g),
      .i_Blu_Video (in_b),
      .o_HSync     (d_hs),
      .o_VSync     (d_vs),
      .o_Red_Video (d_r),
      .o_Grn_Video (d_g),
      .o_Blu_Video (d_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // n = samples since the last frame start (mod frame size); col/row follow directly.
   function automatic exp_t ref_out(input int tc, input int tr, input int ac, input int ar,
                                    input int fph, input int bph, input int fpv,
                                    input int bpv, input int n, input logic hs,
                                    input logic vs, input logic [3:0] r, input logic [3:0] g,
                                    input logic [3:0] b);
      exp_t e;
      int   col, row;
      col  = n % tc;
      row  = n / tc;
      e.hs = !((col >= ac + fph) && (col <= tc - bph - 1));
      e.vs = !((row >= ar + fpv) && (row <= tr - bpv - 1));
      e.r  = (hs && vs) ? r : 4'h0;
      e.g  = (hs && vs) ? g : 4'h0;
      e.b  = (hs && vs) ? b : 4'h0;
      return e;
   endfunction

   task automatic check_dut(input string pfx, input exp_t e, input logic hs, input logic vs,
                            input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
      check_eq({pfx, "_hsync"}, 32'(hs), 32'(e.hs));
      check_eq({pfx, "_vsync"}, 32'(vs), 32'(e.vs));
      check_eq({pfx, "_red"}, 32'(r), 32'(e.r));
      check_eq({pfx, "_grn"}, 32'(g), 32'(e.g));
      check_eq({pfx, "_blu"}, 32'(b), 32'(e.b));
   endtask

   initial begin
      exp_t idle, ps0, ps1, pd0, pd1;
      int   n_s, n_d, ucol, urow, rst_hold, hs_run, vs_run;
      logic prev_vs, fs, arm_async, async_done, arm_inject, stuck;

      idle       = '{hs: 1'b1, vs: 1'b1, r: 4'h0, g: 4'h0, b: 4'h0};
      ps0        = idle;
      ps1        = idle;
      pd0        = idle;
      pd1        = idle;
      n_s        = 0;
      n_d        = 0;
      prev_vs    = 1'b0;
      ucol       = 0;
      urow       = 0;
      rst_hold   = 3;
      hs_run     = 0;
      vs_run     = 0;
      arm_async  = 1'b0;
      async_done = 1'b0;
      arm_inject = 1'b0;
      rst_n      = 1'b0;
      in_hs      = 1'b0;
      in_vs      = 1'b0;
      in_r       = 4'h0;
      in_g       = 4'h0;
      in_b       = 4'h0;

      for (int it = 0; it < 13000; it++) begin
         @(negedge clk);
         check_dut("small", ps1, s_hs, s_vs, s_r, s_g, s_b);
         check_dut("dflt", pd1, d_hs, d_vs, d_r, d_g, d_b);

         // Pulse widths over undisturbed frames: 92 clocks and 3 rows of 40.
         if (it < 3000) begin
            if (!d_hs) hs_run++;
            else begin
               if (hs_run > 0) check_eq("dflt_hs_width", 32'(hs_run), 32'd92);
               hs_run = 0;
            end
            if (!s_vs) vs_run++;
            else begin
               if (vs_run > 0) check_eq("small_vs_width", 32'(vs_run), 32'd120);
               vs_run = 0;
            end
         end

         if (it == 3000) arm_async = 1'b1;
         if (arm_async && !s_hs) begin
            rst_n = 1'b0;
            #1;
            check_eq("async_rst_hsync", 32'(s_hs), 32'd1);
            arm_async  = 1'b0;
            async_done = 1'b1;
            rst_hold   = 5;
         end
         if (rst_hold > 0) rst_hold--;
         else rst_n = 1'b1;

         if (it == 6000) arm_inject = 1'b1;
         stuck = (it >= 9000) && (it < 10600);
         if (arm_inject && urow == 5 && ucol == 0) begin
            // One low sample, then the stream restarts at row 0 -> early VSync rise.
            in_hs      = 1'b0;
            in_vs      = 1'b0;
            arm_inject = 1'b0;
         end else begin
            in_hs = (ucol < SAC);
            in_vs = (urow < SAR);
            if (ucol == STC - 1) begin
               ucol = 0;
               urow = (urow == STR - 1) ? 0 : urow + 1;
            end else begin
               ucol++;
            end
         end
         if (stuck) begin
            in_hs = 1'b0;
            in_vs = 1'b0;
         end
         if (it >= 1000 && it < 2600) begin
            in_r = (in_hs && in_vs) ? 4'hA : 4'h5;
            in_g = in_r;
            in_b = in_r;
         end else begin
            in_r = 4'($urandom);
            in_g = 4'($urandom);
            in_b = 4'($urandom);
         end

         if (!rst_n) begin
            ps0     = idle;
            ps1     = idle;
            pd0     = idle;
            pd1     = idle;
            n_s     = 0;
            n_d     = 0;
            prev_vs = 1'b0;
         end else begin
            ps1     = ps0;
            pd1     = pd0;
            fs      = in_vs && !prev_vs;
            n_s     = fs ? 0 : (n_s + 1) % (STC * STR);
            n_d     = fs ? 0 : (n_d + 1) % (DTC * DTR);
            prev_vs = in_vs;
            ps0 = ref_out(STC, STR, SAC, SAR, SFPH, SBPH, SFPV, SBPV, n_s,
                          in_hs, in_vs, in_r, in_g, in_b);
            pd0 = ref_out(DTC, DTR, DAC, DAR, DFPH, DBPH, DFPV, DBPV, n_d,
                          in_hs, in_vs, in_r, in_g, in_b);
         end
      end

      check_eq("async_rst_done", 32'(async_done), 32'd1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
